fetch_queue: RTL
================

# fetch_queue

Parametrised instruction fetch queue replacing the single fetch pipeline register between the instruction memory and the decode stage. It owns the fetch PC, issues one word address per cycle to the combinational instruction memory, and buffers up to DEPTH fetched instructions with their PC and PC+4. The decode stage consumes entries through a valid/ready handshake. A redirect from execute (taken branch or jump) flushes all buffered entries and restarts fetch at the target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- XLEN, 32: address/instruction width.
- RESET_PC, 32'h0: fetch PC after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits enqueue this cycle; low holds the PC.
- redirect  in  1  flush and restart (PCSrcE).
- redirect_pc  in  XLEN  restart address (PCtarget or ALU result for JALR).
- imem_addr  out  XLEN  current fetch PC to instrmem.
- imem_instr  in  XLEN  word at imem_addr, same cycle.
- dq_valid  out  1  head entry valid.
- dq_ready  in  1  decode accepts head (= !StallD).
- dq_instr  out  XLEN  head instruction; NOP when !dq_valid.
- dq_pc  out  XLEN  head PC.
- dq_pcplus4  out  XLEN  head PC+4.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full  out  1  count == DEPTH.

## Operation
- State: entry array (instr, pc), rd_ptr and wr_ptr of $clog2(DEPTH) bits, count, fetch_pc.
- enq = fetch_en && !redirect && (!full || deq). deq = dq_valid && dq_ready && !redirect.
- On enq: entry[wr_ptr] <= {imem_instr, fetch_pc}; wr_ptr++; fetch_pc <= fetch_pc + 4.
- On deq: rd_ptr++.
- count <= count + enq − deq; enq and deq in the same cycle leave count unchanged. Simultaneous enq and deq when full is legal: the freed slot is written in the same edge.
- Pointers wrap modulo DEPTH by natural overflow.
- dq_valid = (count != 0). dq_instr/dq_pc are taken from entry[rd_ptr]. dq_pcplus4 = dq_pc + 4, modulo 2^XLEN.
- When !dq_valid, dq_instr = 32'h00000013 (NOP) and dq_pc = 0.
- Redirect takes priority over everything else. At the edge: count, rd_ptr and wr_ptr <= 0, and fetch_pc <= redirect_pc. No enqueue or dequeue happens in that cycle, even if dq_ready is high.
- fetch_pc wraps modulo 2^XLEN. Bits [1:0] of redirect_pc are forced to 0.
- No decode stall input beyond dq_ready. The queue never drops or duplicates an entry.

## Timing
- Reset (rst low, async): fetch_pc = RESET_PC, pointers = 0, count = 0, dq_valid = 0, full = 0, dq_instr = NOP, dq_pc = 0, dq_pcplus4 = 4, imem_addr = RESET_PC.
- Latency: an instruction fetched in cycle N is visible at dq_* in cycle N+1. There is no same-cycle bypass.
- After redirect in cycle N: dq_valid = 0 in N+1, and imem_addr = redirect_pc in N+1. The target instruction appears at dq_* in N+2.
- Steady state with dq_ready held high: one instruction per cycle, and count stays at 1.
- With dq_ready low: count climbs by 1 per cycle until full. fetch_pc then holds at head PC + 4·DEPTH.
- Outputs depend combinationally on registered state only. dq_* has no path from dq_ready.

## Structure
- Shared package cpu_pkg: XLEN, NOP_INSTR = 32'h00000013, RESET_PC default, and the typedef fq_entry_t {instr, pc}.
- One sub-module, fq_ram: a DEPTH×fq_entry_t register array with one write port and one asynchronous read port, parametrised by DEPTH. Pointer, count and PC control stays in fetch_queue.
- The cpu top instantiates fetch_queue in place of the pc plus fetchff pair.

## Test plan
- Reset release, fetch_en = 1, dq_ready = 1, imem returns addr^32'hA5A5: dq_valid rises cycle 1 with dq_pc = 0, then dq_pc = 4, 8, … each cycle, and count stays at 1.
- Hold dq_ready = 0 with DEPTH = 4: count goes 1, 2, 3, 4 and full asserts. imem_addr freezes at 16. Release dq_ready: entries drain with PCs 0, 4, 8, 12 in order, with no gap or duplicate.
- When full, pulse dq_ready for one cycle: count stays 4, the head advances to PC 4, and the entry with PC 16 is written.
- With count = 3, assert redirect with redirect_pc = 0x100 and dq_ready = 1: next cycle count = 0 and dq_instr = NOP. The cycle after that, dq_pc = 0x100.
- Apply redirect_pc = 0x103: imem_addr = 0x100.
- Assert rst low mid-stream with count = 2: count = 0, dq_valid = 0 and imem_addr = RESET_PC immediately, without waiting for a clock edge.
- Wrap test: run 3·DEPTH+1 enqueue/dequeue pairs with random dq_ready. A scoreboard checks PC order is strictly +4 between redirects, so the pointers have wrapped several times without corruption.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch reset vector, NOP encoding
// and the fetch-queue entry layout.
package cpu_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

   // One buffered fetch: the instruction word and the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fq_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue_if.sv
// Decode-side valid/ready handshake of the fetch queue. The queue drives the
// head entry (master); the decode stage returns ready (slave).
interface fetch_queue_if #(
   parameter int XLEN = 32
);

   logic            dq_valid;
   logic            dq_ready;
   logic [XLEN-1:0] dq_instr;
   logic [XLEN-1:0] dq_pc;
   logic [XLEN-1:0] dq_pcplus4;

   modport master (
      output dq_valid, dq_instr, dq_pc, dq_pcplus4,
      input  dq_ready
   );

   modport slave (
      input  dq_valid, dq_instr, dq_pc, dq_pcplus4,
      output dq_ready
   );

endinterface : fetch_queue_if

// File: rtl/fq_ram.sv
// DEPTH-entry storage for the fetch queue: one synchronous write port and
// one asynchronous read port. Pointer and occupancy control lives in the top.
module fq_ram
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  fq_entry_t       i_wdata,
   input  logic [AW-1:0]   i_raddr,
   output fq_entry_t       o_rdata
);

   fq_entry_t r_mem [DEPTH];

   // Write the slot addressed by the write pointer on an enqueue.
   // NOTE: storage is deliberately left out of reset; occupancy is tracked by
   // the count in the top, so stale slots are never presented as valid.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : fq_ram

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, fetches one word per cycle
// from the combinational instruction memory, and buffers up to DEPTH
// entries for decode. A redirect flushes everything and restarts fetch.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
   localparam int             AW       = $clog2(DEPTH),
   localparam int             CW       = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_fetch_en,
   input  logic              i_redirect,
   input  logic [XLEN-1:0]   i_redirect_pc,
   output logic [XLEN-1:0]   o_imem_addr,
   input  logic [XLEN-1:0]   i_imem_instr,
   fetch_queue_if.master     dq,
   output logic [CW-1:0]     o_count,
   output logic              o_full
);

   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_fetch_pc;

   logic            w_valid;
   logic            w_enq;
   logic            w_deq;
   logic [CW-1:0]   w_count_next;
   logic [XLEN-1:0] w_redirect_pc;
   fq_entry_t       w_wdata;
   fq_entry_t       w_head;

   assign w_valid       = (r_count != '0);
   assign o_full        = (r_count == CW'(DEPTH));
   assign o_count       = r_count;
   assign o_imem_addr   = r_fetch_pc;

   // Redirect wins over both queue operations; a full queue can still accept
   // a new word when the head leaves in the same cycle.
   assign w_deq         = w_valid && dq.dq_ready && !i_redirect;
   assign w_enq         = i_fetch_en && !i_redirect && (!o_full || w_deq);

   // Targets are word aligned; low address bits are ignored.
   assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);

   assign w_wdata       = '{instr: i_imem_instr, pc: r_fetch_pc};

   fq_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_enq),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Occupancy after this edge: enq and deq together leave it unchanged.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_count_next = r_count;
      unique case ({w_enq, w_deq})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Pointer, occupancy and fetch-PC state; pointers wrap by natural overflow.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_fetch_pc <= RESET_PC;
      end else if (i_redirect) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_fetch_pc <= w_redirect_pc;
      end else begin
         r_count <= w_count_next;
         if (w_enq) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   // Head presentation depends on registered state only; an empty queue
   // shows a NOP at PC 0 so decode sees a harmless bubble.
   assign dq.dq_valid   = w_valid;
   assign dq.dq_instr   = w_valid ? w_head.instr : NOP_INSTR;
   assign dq.dq_pc      = w_valid ? w_head.pc    : '0;
   assign dq.dq_pcplus4 = dq.dq_pc + XLEN'(4);

endmodule : fetch_queue
